posit_accumulate_8: RTL and testbench



---
 rtl/posit_accumulate_8.sv | 149 ++++++++++++++
 tb/tb_posit_accumulate_8.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/posit_accumulate_8.sv
// Reduces a last-terminated stream of 32-bit es=2 posits through an external 8-stage adder.
// Latency: one operand gives sum one cycle after acceptance; longer streams take about LAT+1 cycles per adder round.
// Backpressure: in_ready is high only in ACCUM; sum is held in OUT until sum_ready is seen.
module posit_accumulate_8 (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] add_in1,
  output logic [31:0] add_in2,
  output logic        add_start,
  input  logic [31:0] add_result,
  input  logic        add_done,
  output logic [31:0] sum,
  output logic        sum_valid,
  input  logic        sum_ready,
  output logic        busy
);

  localparam int LAT = 8;

  typedef enum logic [1:0] {
    S_FLUSH = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  flush_cnt_q, flush_cnt_d;
  logic [31:0] fifo_q [0:3];
  logic [31:0] fifo_d [0:3];
  logic [2:0]  occ_q, occ_d;
  logic [3:0]  infl_q, infl_d;
  logic [31:0] add_in1_q, add_in1_d;
  logic [31:0] add_in2_q, add_in2_d;
  logic        add_start_q, add_start_d;
  logic [31:0] sum_q, sum_d;

  logic        issue;
  logic        done_push;
  logic        accept;
  logic [2:0]  wr_ptr;

  assign in_ready  = (state_q == S_ACCUM);
  assign sum_valid = (state_q == S_OUT);
  assign busy      = !((state_q == S_ACCUM) && (occ_q == 3'd0) && (infl_q == 4'd0));
  assign add_in1   = add_in1_q;
  assign add_in2   = add_in2_q;
  assign add_start = add_start_q;
  assign sum       = sum_q;

  // Next-state: pop a pair for the adder, then append adder result and new operand in that order.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    occ_d       = occ_q;
    infl_d      = infl_q;
    add_in1_d   = add_in1_q;
    add_in2_d   = add_in2_q;
    add_start_d = 1'b0;
    sum_d       = sum_q;
    for (int i = 0; i < 4; i++) fifo_d[i] = fifo_q[i];

    // Issue decision uses start-of-cycle occupancy only; this cycle's pushes wait a cycle.
    issue     = (occ_q >= 3'd2);
    // Results arriving during FLUSH belong to operations orphaned by reset.
    done_push = add_done && (state_q != S_FLUSH);
    accept    = in_valid && in_ready;
    wr_ptr    = occ_q;

    if (issue) begin
      add_start_d = 1'b1;
      add_in1_d   = fifo_q[0];
      add_in2_d   = fifo_q[1];
      fifo_d[0]   = fifo_q[2];
      fifo_d[1]   = fifo_q[3];
      wr_ptr      = occ_q - 3'd2;
    end
    if (done_push) begin
      fifo_d[wr_ptr[1:0]] = add_result;
      wr_ptr              = wr_ptr + 3'd1;
    end
    if (accept) begin
      fifo_d[wr_ptr[1:0]] = in_data;
      wr_ptr              = wr_ptr + 3'd1;
    end
    occ_d  = wr_ptr;
    infl_d = infl_q + {3'd0, issue} - {3'd0, done_push};

    case (state_q)
      S_FLUSH: begin
        if (flush_cnt_q == 4'd0) state_d = S_ACCUM;
        else                     flush_cnt_d = flush_cnt_q - 4'd1;
      end
      S_ACCUM: begin
        if (accept && in_last) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // One entry left and nothing in the adder: that entry is the total.
        if ((occ_q == 3'd1) && (infl_q == 4'd0)) begin
          sum_d   = fifo_q[0];
          occ_d   = 3'd0;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (sum_ready) state_d = S_ACCUM;
      end
      default: state_d = S_FLUSH;
    endcase
  end

  // State registers with synchronous reset into FLUSH.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FLUSH;
      flush_cnt_q <= 4'(LAT);
      occ_q       <= 3'd0;
      infl_q      <= 4'd0;
      add_in1_q   <= 32'd0;
      add_in2_q   <= 32'd0;
      add_start_q <= 1'b0;
      sum_q       <= 32'd0;
      for (int i = 0; i < 4; i++) fifo_q[i] <= 32'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      occ_q       <= occ_d;
      infl_q      <= infl_d;
      add_in1_q   <= add_in1_d;
      add_in2_q   <= add_in2_d;
      add_start_q <= add_start_d;
      sum_q       <= sum_d;
      for (int i = 0; i < 4; i++) fifo_q[i] <= fifo_d[i];
    end
  end

  // A full buffer or more in-flight ops than adder stages means the issue rule was broken.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (occ_q <= 3'd3);
      assert (infl_q <= 4'(LAT));
    end
  end

endmodule

// File: tb/tb_posit_accumulate_8.sv
// Bench for posit_accumulate_8 with a non-resettable 8-stage posit adder model.
// Latency: expected sums are queued at stimulus time and popped when sum_valid appears.
// Backpressure: sum_ready is driven per scenario, including a long stall in OUT.
module tb_posit_accumulate_8;

  localparam int LAT = 8;
  localparam logic [31:0] NAR = 32'h80000000;

  logic        clk;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] add_in1;
  logic [31:0] add_in2;
  logic        add_start;
  logic [31:0] add_result;
  logic        add_done;
  logic [31:0] sum;
  logic        sum_valid;
  logic        sum_ready;
  logic        busy;

  posit_accumulate_8 dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .add_in1(add_in1), .add_in2(add_in2), .add_start(add_start),
    .add_result(add_result), .add_done(add_done),
    .sum(sum), .sum_valid(sum_valid), .sum_ready(sum_ready), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_starts = 0;
  int occ_over = 0;
  int ready_drops = 0;
  logic [31:0] stim_q[$];
  logic [31:0] exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- posit32 es=2 arithmetic via reals ----------------
  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) for (int j = 0; j < n; j++) r = r * 2.0;
    else        for (int j = 0; j < -n; j++) r = r / 2.0;
    return r;
  endfunction

  function automatic real p2r(input logic [31:0] p);
    logic [31:0] v;
    int k, i, e;
    real f, w;
    if (p == 32'd0) return 0.0;
    v = p[31] ? -p : p;
    i = 30;
    if (v[30]) begin
      k = -1;
      while (i >= 0 && v[i]) begin k++; i--; end
    end else begin
      k = 0;
      while (i >= 0 && !v[i]) begin k--; i--; end
    end
    i--;
    e = 0;
    for (int j = 0; j < 2; j++) begin
      e = e * 2;
      if (i >= 0) e = e + int'(v[i]);
      i--;
    end
    f = 0.0; w = 0.5;
    while (i >= 0) begin
      if (v[i]) f = f + w;
      w = w / 2.0;
      i--;
    end
    return p[31] ? -(1.0 + f) * pow2(4 * k + e) : (1.0 + f) * pow2(4 * k + e);
  endfunction

  function automatic logic [31:0] r2p(input real x);
    logic [127:0] bits;
    logic [31:0]  r;
    logic         s;
    real          a, f;
    int           e, k, ex, pos;
    if (x == 0.0) return 32'd0;
    s = (x < 0.0);
    a = s ? -x : x;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    k  = (e >= 0) ? e / 4 : -((-e + 3) / 4);
    ex = e - 4 * k;
    if (k > 29) r = 32'h7FFFFFFF;
    else if (k < -30) r = 32'h00000001;
    else begin
      bits = '0;
      pos = 127;
      if (k >= 0) begin
        for (int j = 0; j <= k; j++) begin bits[pos] = 1'b1; pos--; end
        pos--;
      end else begin
        pos = pos + k;
        bits[pos] = 1'b1; pos--;
      end
      bits[pos] = ex[1]; pos--;
      bits[pos] = ex[0]; pos--;
      f = a - 1.0;
      for (int j = 0; j < 60 && pos >= 0; j++) begin
        f = f * 2.0;
        if (f >= 1.0) begin bits[pos] = 1'b1; f = f - 1.0; end
        pos--;
      end
      r = {1'b0, bits[127:97]};
      if (bits[96] && ((|bits[95:0]) || r[0])) r = r + 32'd1;
    end
    return s ? -r : r;
  endfunction

  function automatic logic [31:0] posit_add(input logic [31:0] a, input logic [31:0] b);
    if (a == NAR || b == NAR) return NAR;
    return r2p(p2r(a) + p2r(b));
  endfunction

  // Expected total: replays the pending-buffer order for a back-to-back stream.
  function automatic logic [31:0] ref_sum();
    logic [31:0] fifo[$];
    logic [31:0] pend_v[$];
    int          pend_t[$];
    logic [31:0] a, b;
    bit          iss;
    int          n_ops = stim_q.size();
    for (int n = 0; n < 20000; n++) begin
      iss = (fifo.size() >= 2);
      if (iss) begin a = fifo.pop_front(); b = fifo.pop_front(); end
      if (pend_t.size() > 0 && pend_t[0] == n) begin
        fifo.push_back(pend_v.pop_front());
        void'(pend_t.pop_front());
      end
      if (n < n_ops) fifo.push_back(stim_q[n]);
      if (iss) begin
        pend_v.push_back(posit_add(a, b));
        pend_t.push_back(n + LAT + 1);
      end
      if (n >= n_ops - 1 && fifo.size() == 1 && pend_t.size() == 0) return fifo[0];
    end
    return 32'hDEADBEEF;
  endfunction

  // ---------------- adder model (no reset, like the real adder) ----------------
  logic [31:0] pipe_d [0:LAT-1];
  logic        pipe_v [0:LAT-1];
  initial for (int i = 0; i < LAT; i++) begin pipe_v[i] = 1'b0; pipe_d[i] = 32'd0; end

  always @(posedge clk) begin
    pipe_v[0] <= (add_start === 1'b1);
    pipe_d[0] <= (add_start === 1'b1) ? posit_add(add_in1, add_in2) : 32'd0;
    for (int i = 1; i < LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end
  assign add_done   = pipe_v[LAT-1];
  assign add_result = pipe_d[LAT-1];

  // Monitors: adder issue count and buffer occupancy bound.
  always @(posedge clk) if (add_start === 1'b1) n_starts++;
  always @(negedge clk) if (!reset && dut.occ_q > 3'd3) occ_over++;

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready, drives stim_q back to back, then counts cycles to sum_valid.
  task automatic drive_stream(output int lat);
    int c;
    for (c = 0; c < 100; c++) begin
      if (in_ready) break;
      step();
    end
    n_checks++;
    if (c >= 100) $display("FAIL stream_ready_wait in_ready=%b required 1", in_ready);
    else n_pass++;
    for (int i = 0; i < stim_q.size(); i++) begin
      in_valid = 1'b1;
      in_data  = stim_q[i];
      in_last  = (i == stim_q.size() - 1);
      if (in_ready !== 1'b1) ready_drops++;
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    lat = 0;
    while (sum_valid !== 1'b1 && lat < 3000) begin
      step();
      lat++;
    end
  endtask

  task automatic check_sum(input string name);
    logic [31:0] e;
    n_checks++;
    if (sum_valid !== 1'b1) $display("FAIL %s sum_valid timeout got %b required 1", name, sum_valid);
    else if (exp_q.size() == 0) $display("FAIL %s scoreboard empty got sum=%h", name, sum);
    else begin
      e = exp_q.pop_front();
      if (sum !== e) $display("FAIL %s sum got %h required %h", name, sum, e);
      else n_pass++;
    end
  endtask

  task automatic accept_sum();
    sum_ready = 1'b1;
    step();
    sum_ready = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int cnt;
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; sum_ready = 1'b0;
    repeat (3) step();
    n_checks++; if (in_ready !== 1'b0)   $display("FAIL rst_in_ready got %b required 0", in_ready); else n_pass++;
    n_checks++; if (add_start !== 1'b0)  $display("FAIL rst_add_start got %b required 0", add_start); else n_pass++;
    n_checks++; if (add_in1 !== 32'd0 || add_in2 !== 32'd0)
                  $display("FAIL rst_add_in got %h/%h required 0/0", add_in1, add_in2); else n_pass++;
    n_checks++; if (sum !== 32'd0)       $display("FAIL rst_sum got %h required 0", sum); else n_pass++;
    n_checks++; if (sum_valid !== 1'b0)  $display("FAIL rst_sum_valid got %b required 0", sum_valid); else n_pass++;
    n_checks++; if (busy !== 1'b1)       $display("FAIL rst_busy got %b required 1", busy); else n_pass++;
    reset = 1'b0;
    cnt = 0;
    while (cnt < 50) begin
      step();
      cnt++;
      if (in_ready === 1'b1) break;
    end
    n_checks++; if (cnt != LAT + 1) $display("FAIL first_in_ready cycles got %0d required %0d", cnt, LAT + 1); else n_pass++;
  endtask

  task automatic test_single();
    int lat, s0;
    stim_q = '{32'h40000000};
    exp_q.push_back(32'h40000000);
    s0 = n_starts;
    drive_stream(lat);
    n_checks++; if (lat != 1) $display("FAIL single_latency got %0d required 1", lat); else n_pass++;
    check_sum("single");
    n_checks++; if (n_starts - s0 != 0) $display("FAIL single_starts got %0d required 0", n_starts - s0); else n_pass++;
    accept_sum();
  endtask

  task automatic test_four_ones();
    int lat, s0;
    stim_q = '{32'h40000000, 32'h40000000, 32'h40000000, 32'h40000000};
    exp_q.push_back(32'h50000000);
    s0 = n_starts;
    drive_stream(lat);
    check_sum("four_ones");
    n_checks++; if (n_starts - s0 != 3) $display("FAIL four_ones_starts got %0d required 3", n_starts - s0); else n_pass++;
    accept_sum();
  endtask

  task automatic test_cancel_nar();
    int lat;
    stim_q = '{32'h40000000, 32'hC0000000};
    exp_q.push_back(32'h00000000);
    drive_stream(lat);
    check_sum("cancel");
    accept_sum();
    stim_q = '{32'h40000000, NAR, 32'h48000000};
    exp_q.push_back(NAR);
    drive_stream(lat);
    check_sum("nar");
    accept_sum();
  endtask

  task automatic test_random();
    int lat, ov0;
    logic [31:0] r;
    stim_q = {};
    for (int i = 0; i < 32; i++) begin
      r = $urandom;
      if (r == NAR) r = 32'h40000000;
      stim_q.push_back(r);
    end
    exp_q.push_back(ref_sum());
    ready_drops = 0;
    ov0 = occ_over;
    drive_stream(lat);
    check_sum("random32");
    n_checks++; if (ready_drops != 0) $display("FAIL random_in_ready_drops got %0d required 0", ready_drops); else n_pass++;
    n_checks++; if (occ_over != ov0) $display("FAIL random_occ_over3 got %0d required 0", occ_over - ov0); else n_pass++;
    accept_sum();
  endtask

  task automatic test_hold();
    int lat, bad;
    stim_q = '{32'h48000000};
    exp_q.push_back(32'h48000000);
    drive_stream(lat);
    check_sum("hold_first");
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sum !== 32'h48000000 || sum_valid !== 1'b1 || in_ready !== 1'b0) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL hold_stable bad_cycles got %0d required 0", bad); else n_pass++;
    accept_sum();
    n_checks++; if (in_ready !== 1'b1) $display("FAIL release_in_ready got %b required 1", in_ready); else n_pass++;
    n_checks++; if (sum_valid !== 1'b0) $display("FAIL release_sum_valid got %b required 0", sum_valid); else n_pass++;
  endtask

  task automatic test_orphan();
    int lat, s0, c;
    bit hit;
    hit = 1'b0;
    for (c = 0; c < 100 && !in_ready; c++) step();
    for (c = 0; c < 32; c++) begin
      in_valid = 1'b1; in_last = 1'b0; in_data = 32'h40000000;
      step();
      if (dut.infl_q == 4'd5) begin hit = 1'b1; break; end
    end
    n_checks++; if (!hit) $display("FAIL orphan_reach_infl5 got %0d required 5", dut.infl_q); else n_pass++;
    in_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (sum_valid !== 1'b0 || busy !== 1'b1)
                  $display("FAIL orphan_reset_state sum_valid=%b busy=%b required 0/1", sum_valid, busy); else n_pass++;
    stim_q = '{32'h48000000, 32'h48000000};
    exp_q.push_back(32'h50000000);
    s0 = n_starts;
    drive_stream(lat);
    n_checks++; if (lat != LAT + 3) $display("FAIL pair_latency got %0d required %0d", lat, LAT + 3); else n_pass++;
    check_sum("after_orphan");
    n_checks++; if (n_starts - s0 != 1) $display("FAIL after_orphan_starts got %0d required 1", n_starts - s0); else n_pass++;
    accept_sum();
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; sum_ready = 1'b0;
    test_reset();
    test_single();
    test_four_ones();
    test_cancel_nar();
    test_random();
    test_hold();
    test_orphan();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
